seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver_if.sv | 24 ++
 rtl/seg7_scan_driver.sv | 169 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Bundles the timer-side digit codes and the multiplexed display outputs of seg7_scan_driver.
interface seg7_scan_driver_if;
  logic            display_en;
  logic [5:0][6:0] digit_seg_in;
  logic [6:0]      seg_out;
  logic [5:0]      digit_sel_b;
  logic            frame_start;

  modport master (
    output display_en,
    output digit_seg_in,
    input  seg_out,
    input  digit_sel_b,
    input  frame_start
  );

  modport slave (
    input  display_en,
    input  digit_seg_in,
    output seg_out,
    output digit_sel_b,
    output frame_start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver with per-frame coherent snapshot.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros of the hours field.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DWELL   = 1000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic               sys_clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int unsigned DWELL_W = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
  localparam int unsigned BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DWELL - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [6:0] SEG_ZERO = 7'b0000001;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [5:0] SEL_NONE = 6'b111111;
  localparam logic [2:0] IDX_LAST = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  state_e               state_r, state_nxt_s;
  logic [2:0]           idx_r, idx_nxt_s;
  logic [DWELL_W-1:0]   dwell_r, dwell_nxt_s;
  logic [BLANK_W-1:0]   blank_r, blank_nxt_s;
  logic [5:0][6:0]      snap_r;
  logic                 capture_s;
  logic [6:0]           seg_nxt_s;
  logic [5:0]           sel_nxt_s;

  // Hours-field leading-zero suppression happens once, at capture, so the scan path stays simple.
  function automatic logic [5:0][6:0] capture_code(input logic [5:0][6:0] raw);
    logic [5:0][6:0] code;
    code = raw;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (raw[5] == SEG_ZERO) begin
      code[5] = SEG_OFF;
      if (raw[4] == SEG_ZERO) begin
        code[4] = SEG_OFF;
      end else begin
        code[4] = raw[4];
      end
    end else begin
      code[5] = raw[5];
    end
`endif
    return code;
  endfunction

  function automatic logic [6:0] pick_digit(input logic [5:0][6:0] snap, input logic [2:0] idx);
    logic [6:0] code;
    case (idx)
      3'd0:    code = snap[0];
      3'd1:    code = snap[1];
      3'd2:    code = snap[2];
      3'd3:    code = snap[3];
      3'd4:    code = snap[4];
      3'd5:    code = snap[5];
      default: code = SEG_OFF;
    endcase
    return code;
  endfunction

  // Next-state, counter and capture decisions for the scan sequence.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    dwell_nxt_s = dwell_r;
    blank_nxt_s = blank_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        idx_nxt_s   = 3'd0;
        dwell_nxt_s = '0;
        blank_nxt_s = '0;
        if (bus.display_en) begin
          state_nxt_s = BLANK;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BLANK: begin
        if (!bus.display_en) begin
          state_nxt_s = IDLE;
          idx_nxt_s   = 3'd0;
          dwell_nxt_s = '0;
          blank_nxt_s = '0;
        end else if (blank_r == BLANK_LAST) begin
          state_nxt_s = DRIVE;
          blank_nxt_s = '0;
          dwell_nxt_s = '0;
        end else begin
          blank_nxt_s = blank_r + BLANK_W'(1);
        end
      end
      DRIVE: begin
        if (!bus.display_en) begin
          state_nxt_s = IDLE;
          idx_nxt_s   = 3'd0;
          dwell_nxt_s = '0;
          blank_nxt_s = '0;
        end else if (dwell_r == DWELL_LAST) begin
          state_nxt_s = BLANK;
          dwell_nxt_s = '0;
          // Wrapping back to digit 0 starts a new frame, hence a fresh snapshot.
          if (idx_r == IDX_LAST) begin
            idx_nxt_s = 3'd0;
            capture_s = 1'b1;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end else begin
          dwell_nxt_s = dwell_r + DWELL_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = 3'd0;
        dwell_nxt_s = '0;
        blank_nxt_s = '0;
      end
    endcase
  end

  // Output values for the upcoming state, registered below so the pins are glitch-free.
  always_comb begin
    seg_nxt_s = SEG_OFF;
    sel_nxt_s = SEL_NONE;
    if (state_nxt_s == DRIVE) begin
      seg_nxt_s = pick_digit(snap_r, idx_nxt_s);
      sel_nxt_s = ~(6'd1 << idx_nxt_s);
    end else begin
      seg_nxt_s = SEG_OFF;
      sel_nxt_s = SEL_NONE;
    end
  end

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r         <= IDLE;
      idx_r           <= 3'd0;
      dwell_r         <= '0;
      blank_r         <= '0;
      snap_r          <= {6{SEG_ZERO}};
      bus.seg_out     <= SEG_OFF;
      bus.digit_sel_b <= SEL_NONE;
      bus.frame_start <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      idx_r           <= idx_nxt_s;
      dwell_r         <= dwell_nxt_s;
      blank_r         <= blank_nxt_s;
      if (capture_s) begin
        snap_r <= capture_code(bus.digit_seg_in);
      end
      bus.seg_out     <= seg_nxt_s;
      bus.digit_sel_b <= sel_nxt_s;
      bus.frame_start <= capture_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver against a frame-position reference model.
module tb_seg7_scan_driver;

  localparam int D     = 4;
  localparam int B     = 2;
  localparam int P     = B + D;
  localparam int FRAME = 6 * P;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_CODE = 7'h7F;
`else
  localparam logic [6:0] LZ_CODE = 7'h01;
`endif

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  seg7_scan_driver_if bus();

  seg7_scan_driver #(.SCAN_DWELL(D), .BLANK_CYCLES(B)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_on   = 1'b0;

  // Reference model: whether scanning, position within the frame, and the captured frame.
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [6:0] m_snap [6];
  logic [6:0] exp_seg;
  logic [5:0] exp_sel;
  logic       exp_fs;

  task automatic model_capture();
    for (int i = 0; i < 6; i++) m_snap[i] = bus.digit_seg_in[i];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (bus.digit_seg_in[5] == 7'h01) begin
      m_snap[5] = 7'h7F;
      if (bus.digit_seg_in[4] == 7'h01) m_snap[4] = 7'h7F;
    end
`endif
  endtask

  task automatic model_step();
    int d;
    int w;
    if (rst) begin
      m_active = 1'b0;
      for (int i = 0; i < 6; i++) m_snap[i] = 7'h01;
    end else if (!bus.display_en) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_pos    = 0;
      model_capture();
    end else begin
      m_pos = (m_pos + 1) % FRAME;
      if (m_pos == 0) model_capture();
    end
    exp_seg = 7'h7F;
    exp_sel = 6'h3F;
    exp_fs  = 1'b0;
    if (m_active) begin
      d      = m_pos / P;
      w      = m_pos % P;
      exp_fs = (m_pos == 0);
      if (w >= B) begin
        exp_seg = m_snap[d];
        exp_sel = ~(6'd1 << d);
      end
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
  endtask

  task automatic restart();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_table();
    bus.digit_seg_in[0] = 7'h01;
    bus.digit_seg_in[1] = 7'h4F;
    bus.digit_seg_in[2] = 7'h12;
    bus.digit_seg_in[3] = 7'h06;
    bus.digit_seg_in[4] = 7'h4C;
    bus.digit_seg_in[5] = 7'h24;
  endtask

  // At most one digit enabled in any cycle.
  always @(negedge sys_clk) begin
    if (mon_on) begin
      n_checks++;
      if ($countones(~bus.digit_sel_b) > 1) begin
        n_errors++;
        $display("FAIL onehot: digit_sel_b=%b, expected at most one low bit", bus.digit_sel_b);
      end
    end
  end

  task automatic test_reset();
    bus.display_en = 1'b1;
    for (int i = 0; i < 6; i++) bus.digit_seg_in[i] = 7'($urandom);
    rst = 1'b1;
    tick();
    tick();
    mon_on = 1'b1;
    n_checks++;
    if ({bus.seg_out, bus.digit_sel_b, bus.frame_start} !== {7'h7F, 6'h3F, 1'b0}) begin
      n_errors++;
      $display("FAIL reset: seg=%h sel=%b fs=%b, expected seg=7f sel=111111 fs=0",
               bus.seg_out, bus.digit_sel_b, bus.frame_start);
    end
  endtask

  task automatic test_frame_timing();
    set_table();
    bus.display_en = 1'b1;
    restart();
    for (int c = 1; c <= 40; c++) begin
      tick();
      n_checks++;
      if ({bus.seg_out, bus.digit_sel_b, bus.frame_start} !== {exp_seg, exp_sel, exp_fs}) begin
        n_errors++;
        $display("FAIL timing c%0d: seg=%h sel=%b fs=%b, expected seg=%h sel=%b fs=%b",
                 c, bus.seg_out, bus.digit_sel_b, bus.frame_start, exp_seg, exp_sel, exp_fs);
      end
      if (c == 1 || c == 37) begin
        n_checks++;
        if (bus.frame_start !== 1'b1) begin
          n_errors++;
          $display("FAIL timing_fs c%0d: frame_start=%b, expected 1", c, bus.frame_start);
        end
      end
      if (c == 2 || c == 8) begin
        n_checks++;
        if ({bus.seg_out, bus.digit_sel_b} !== {7'h7F, 6'h3F}) begin
          n_errors++;
          $display("FAIL timing_blank c%0d: seg=%h sel=%b, expected all-off", c, bus.seg_out, bus.digit_sel_b);
        end
      end
      if (c == 3 || c == 6) begin
        n_checks++;
        if ({bus.seg_out, bus.digit_sel_b} !== {7'h01, 6'b111110}) begin
          n_errors++;
          $display("FAIL timing_d0 c%0d: seg=%h sel=%b, expected seg=01 sel=111110", c, bus.seg_out, bus.digit_sel_b);
        end
      end
      if (c == 9) begin
        n_checks++;
        if ({bus.seg_out, bus.digit_sel_b} !== {7'h4F, 6'b111101}) begin
          n_errors++;
          $display("FAIL timing_d1 c%0d: seg=%h sel=%b, expected seg=4f sel=111101", c, bus.seg_out, bus.digit_sel_b);
        end
      end
    end
  endtask

  task automatic test_coherency();
    set_table();
    bus.display_en = 1'b1;
    restart();
    for (int c = 1; c <= 42; c++) begin
      if (c == 2) bus.digit_seg_in[0] = 7'h4F;
      tick();
      n_checks++;
      if ({bus.seg_out, bus.digit_sel_b, bus.frame_start} !== {exp_seg, exp_sel, exp_fs}) begin
        n_errors++;
        $display("FAIL coherency c%0d: seg=%h sel=%b fs=%b, expected seg=%h sel=%b fs=%b",
                 c, bus.seg_out, bus.digit_sel_b, bus.frame_start, exp_seg, exp_sel, exp_fs);
      end
      if (c == 4) begin
        n_checks++;
        if (bus.seg_out !== 7'h01) begin
          n_errors++;
          $display("FAIL coherency_old: seg=%h, expected 01", bus.seg_out);
        end
      end
      if (c == 40) begin
        n_checks++;
        if (bus.seg_out !== 7'h4F) begin
          n_errors++;
          $display("FAIL coherency_new: seg=%h, expected 4f", bus.seg_out);
        end
      end
    end
  endtask

  task automatic test_disable();
    for (int i = 0; i < 6; i++) bus.digit_seg_in[i] = 7'($urandom);
    bus.display_en = 1'b1;
    restart();
    for (int c = 1; c <= 30; c++) begin
      if (c == 23) bus.display_en = 1'b0;
      if (c == 24) bus.display_en = 1'b1;
      tick();
      n_checks++;
      if ({bus.seg_out, bus.digit_sel_b, bus.frame_start} !== {exp_seg, exp_sel, exp_fs}) begin
        n_errors++;
        $display("FAIL disable c%0d: seg=%h sel=%b fs=%b, expected seg=%h sel=%b fs=%b",
                 c, bus.seg_out, bus.digit_sel_b, bus.frame_start, exp_seg, exp_sel, exp_fs);
      end
      if (c == 23) begin
        n_checks++;
        if ({bus.seg_out, bus.digit_sel_b, bus.frame_start} !== {7'h7F, 6'h3F, 1'b0}) begin
          n_errors++;
          $display("FAIL disable_off: seg=%h sel=%b fs=%b, expected all-off", bus.seg_out, bus.digit_sel_b, bus.frame_start);
        end
      end
      if (c == 24) begin
        n_checks++;
        if (bus.frame_start !== 1'b1) begin
          n_errors++;
          $display("FAIL disable_fs: frame_start=%b, expected 1", bus.frame_start);
        end
      end
      if (c == 27) begin
        n_checks++;
        if (bus.digit_sel_b !== 6'b111110) begin
          n_errors++;
          $display("FAIL disable_d0: sel=%b, expected 111110", bus.digit_sel_b);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) bus.digit_seg_in[i] = 7'($urandom);
    bus.display_en = 1'b1;
    restart();
    for (int c = 1; c <= 30; c++) begin
      rst = (c == 17);
      tick();
      n_checks++;
      if ({bus.seg_out, bus.digit_sel_b, bus.frame_start} !== {exp_seg, exp_sel, exp_fs}) begin
        n_errors++;
        $display("FAIL reset_mid c%0d: seg=%h sel=%b fs=%b, expected seg=%h sel=%b fs=%b",
                 c, bus.seg_out, bus.digit_sel_b, bus.frame_start, exp_seg, exp_sel, exp_fs);
      end
      if (c == 17) begin
        n_checks++;
        if ({bus.seg_out, bus.digit_sel_b, bus.frame_start} !== {7'h7F, 6'h3F, 1'b0}) begin
          n_errors++;
          $display("FAIL reset_mid_off: seg=%h sel=%b fs=%b, expected all-off", bus.seg_out, bus.digit_sel_b, bus.frame_start);
        end
      end
      if (c == 18 || c == 21) begin
        n_checks++;
        if ((c == 18 && bus.frame_start !== 1'b1) || (c == 21 && bus.digit_sel_b !== 6'b111110)) begin
          n_errors++;
          $display("FAIL reset_mid_restart c%0d: fs=%b sel=%b, expected fs=1 at c18, sel=111110 at c21",
                   c, bus.frame_start, bus.digit_sel_b);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_leading_zero();
    for (int i = 0; i < 4; i++) bus.digit_seg_in[i] = 7'($urandom);
    bus.digit_seg_in[4] = 7'h01;
    bus.digit_seg_in[5] = 7'h01;
    bus.display_en = 1'b1;
    restart();
    for (int c = 1; c <= FRAME; c++) begin
      tick();
      n_checks++;
      if ({bus.seg_out, bus.digit_sel_b, bus.frame_start} !== {exp_seg, exp_sel, exp_fs}) begin
        n_errors++;
        $display("FAIL lead_zero c%0d: seg=%h sel=%b fs=%b, expected seg=%h sel=%b fs=%b",
                 c, bus.seg_out, bus.digit_sel_b, bus.frame_start, exp_seg, exp_sel, exp_fs);
      end
      if (bus.digit_sel_b == 6'b011111 || bus.digit_sel_b == 6'b101111) begin
        n_checks++;
        if (bus.seg_out !== LZ_CODE) begin
          n_errors++;
          $display("FAIL lead_zero_hours c%0d: seg=%h, expected %h", c, bus.seg_out, LZ_CODE);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) bus.digit_seg_in[i] = 7'($urandom);
    bus.display_en = 1'b1;
    restart();
    for (int c = 1; c <= 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 39) == 0) bus.display_en = ~bus.display_en;
      if ($urandom_range(0, 5) == 0) begin
        int k;
        k = int'($urandom_range(0, 5));
        if ($urandom_range(0, 2) == 0) bus.digit_seg_in[k] = 7'h01;
        else bus.digit_seg_in[k] = 7'($urandom);
      end
      tick();
      n_checks++;
      if ({bus.seg_out, bus.digit_sel_b, bus.frame_start} !== {exp_seg, exp_sel, exp_fs}) begin
        n_errors++;
        $display("FAIL random c%0d: seg=%h sel=%b fs=%b, expected seg=%h sel=%b fs=%b",
                 c, bus.seg_out, bus.digit_sel_b, bus.frame_start, exp_seg, exp_sel, exp_fs);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.display_en   = 1'b0;
    bus.digit_seg_in = '0;
    for (int i = 0; i < 6; i++) m_snap[i] = 7'h01;
    @(negedge sys_clk);
    test_reset();
    test_frame_timing();
    test_coherency();
    test_disable();
    test_reset_mid();
    test_leading_zero();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
